// File: rtl/Common.sv
// Shared types and constants for the MLP block family: activation selector,
// numerical guard epsilon and the epoch-driver state encoding.
package Common;

    typedef enum logic [1:0] {
        ACT_SIGMOID,
        ACT_RELU,
        ACT_TANH,
        ACT_LINEAR
    } act_func;

    localparam real epsilon = 1.0e-7;

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        EVAL,
        DONE
    } driver_state_t;

endpackage

// File: rtl/mlp_sample_store.sv
// Sample table for the MLP epoch driver: one synchronous write port and one
// combinational read port; out-of-range write indices are dropped.
module mlp_sample_store
    import Common::*;
#(
    parameter int inputs      = 2,
    parameter int outputs     = 1,
    parameter int num_samples = 4,
    parameter int idx_w       = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [idx_w-1:0] wr_idx,
    input  real              wr_values   [inputs-1:0],
    input  real              wr_expected [outputs-1:0],
    input  logic [idx_w-1:0] rd_idx,
    output real              rd_values   [inputs-1:0],
    output real              rd_expected [outputs-1:0]
);

    real values_mem   [num_samples-1:0][inputs-1:0];
    real expected_mem [num_samples-1:0][outputs-1:0];

    // NOTE: no reset on the table; loaded samples must survive rst.
    always_ff @(posedge clk) begin
        if (we && (int'(wr_idx) < num_samples)) begin
            for (int i = 0; i < inputs; i++) begin
                values_mem[wr_idx][i] <= wr_values[i];
            end
            for (int k = 0; k < outputs; k++) begin
                expected_mem[wr_idx][k] <= wr_expected[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < inputs; i++) begin
            rd_values[i] = values_mem[rd_idx][i];
        end
        for (int k = 0; k < outputs; k++) begin
            rd_expected[k] = expected_mem[rd_idx][k];
        end
    end

endmodule

// File: rtl/mlp_epoch_driver.sv
// Epoch sequencer feeding an MLP: TRAIN pass then EVAL pass per epoch, two-cycle
// sample slots. Define MLP_DRIVER_COST_EN to add the binary cross-entropy output cost.
module mlp_epoch_driver
    import Common::*;
#(
    parameter int  inputs      = 2,
    parameter int  outputs     = 1,
    parameter int  num_samples = 4,
    parameter int  num_epochs  = 100,
    parameter real threshold   = 0.5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           load_en,
    input  logic [$clog2(num_samples)-1:0] load_idx,
    input  real                            load_values   [inputs-1:0],
    input  real                            load_expected [outputs-1:0],
    output real                            values        [inputs-1:0],
    output real                            expected      [outputs-1:0],
    output logic                           training,
    input  real                            prediction    [outputs-1:0],
    output logic                           busy,
    output logic                           done,
    output int                             epoch,
    output int                             correct
`ifdef MLP_DRIVER_COST_EN
    ,
    output real                            cost
`endif
);

    localparam int idx_w = $clog2(num_samples);
    localparam logic [idx_w-1:0] last_idx = idx_w'(num_samples - 1);

    driver_state_t    state, state_next;
    logic [idx_w-1:0] sample_idx;
    logic             phase_b;
    logic             last_slot;
    logic             sample_ok;
    int               partial;
    real              rd_values   [inputs-1:0];
    real              rd_expected [outputs-1:0];

    mlp_sample_store #(
        .inputs      (inputs),
        .outputs     (outputs),
        .num_samples (num_samples),
        .idx_w       (idx_w)
    ) u_store (
        .clk         (clk),
        .we          (load_en && (state == IDLE)),
        .wr_idx      (load_idx),
        .wr_values   (load_values),
        .wr_expected (load_expected),
        .rd_idx      (sample_idx),
        .rd_values   (rd_values),
        .rd_expected (rd_expected)
    );

    assign last_slot = phase_b && (sample_idx == last_idx);

    always_comb begin
        sample_ok = 1'b1;
        for (int k = 0; k < outputs; k++) begin
            if ((prediction[k] < threshold) != (rd_expected[k] < threshold)) begin
                sample_ok = 1'b0;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        training   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = TRAIN;
            TRAIN: begin
                busy     = 1'b1;
                training = 1'b1;
                if (last_slot) state_next = EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                if (last_slot) state_next = (epoch + 1 >= num_epochs) ? DONE : TRAIN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < inputs; i++) begin
            values[i] = busy ? rd_values[i] : 0.0;
        end
        for (int k = 0; k < outputs; k++) begin
            expected[k] = busy ? rd_expected[k] : 0.0;
        end
    end

    // NOTE: state updates use non-blocking assignment so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sample_idx <= '0;
            phase_b    <= 1'b0;
            epoch      <= 0;
            correct    <= 0;
            partial    <= 0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && start) begin
                epoch   <= 0;
                correct <= 0;
                partial <= 0;
            end
            if (busy) begin
                phase_b <= !phase_b;
                if (phase_b) sample_idx <= last_slot ? '0 : sample_idx + idx_w'(1);
            end
            if ((state == EVAL) && phase_b) begin
                if (last_slot) begin
                    correct <= partial + int'(sample_ok);
                    partial <= 0;
                    epoch   <= epoch + 1;
                end else begin
                    partial <= partial + int'(sample_ok);
                end
            end
        end
    end

`ifdef MLP_DRIVER_COST_EN
    real cost_partial;
    real sample_cost;

    always_comb begin
        sample_cost = -(rd_expected[0] * $ln(prediction[0] + epsilon)
                        + (1.0 - rd_expected[0]) * $ln(1.0 - prediction[0] + epsilon));
    end

    // Cost is published together with correct at the end of each EVAL pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cost         <= 0.0;
            cost_partial <= 0.0;
        end else if ((state == IDLE) && start) begin
            cost         <= 0.0;
            cost_partial <= 0.0;
        end else if ((state == EVAL) && phase_b) begin
            if (last_slot) begin
                cost         <= cost_partial + sample_cost;
                cost_partial <= 0.0;
            end else begin
                cost_partial <= cost_partial + sample_cost;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mlp_epoch_driver.sv
// Directed bench for mlp_epoch_driver: XOR table, two epochs per run, stub MLP
// returning either the expected value or a constant 0.5.
module tb_mlp_epoch_driver;

    localparam int n_in  = 2;
    localparam int n_out = 1;
    localparam int n_ep  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       load_en;
    logic [1:0] load_idx;
    real        load_values   [n_in-1:0];
    real        load_expected [n_out-1:0];
    real        values        [n_in-1:0];
    real        expected      [n_out-1:0];
    real        prediction    [n_out-1:0];
    logic       training;
    logic       busy;
    logic       done;
    int         epoch;
    int         correct;
`ifdef MLP_DRIVER_COST_EN
    real        cost;
`endif

    bit pred_const;
    int vectors     = 0;
    int miscompares = 0;

    real xor_a [4] = '{0.0, 0.0, 1.0, 1.0};
    real xor_b [4] = '{0.0, 1.0, 0.0, 1.0};
    real xor_y [4] = '{0.0, 1.0, 1.0, 0.0};

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < n_out; k++) begin
            prediction[k] = pred_const ? 0.5 : expected[k];
        end
    end

    mlp_epoch_driver #(
        .inputs      (n_in),
        .outputs     (n_out),
        .num_samples (4),
        .num_epochs  (n_ep),
        .threshold   (0.5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_en       (load_en),
        .load_idx      (load_idx),
        .load_values   (load_values),
        .load_expected (load_expected),
        .values        (values),
        .expected      (expected),
        .training      (training),
        .prediction    (prediction),
        .busy          (busy),
        .done          (done),
        .epoch         (epoch),
        .correct       (correct)
`ifdef MLP_DRIVER_COST_EN
        ,
        .cost          (cost)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_real(input string tag, input real obs, input real exp);
        vectors++;
        assert ((obs - exp < 1.0e-3) && (exp - obs < 1.0e-3)) else begin
            miscompares++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    // Entered in cycle 0 with start already driven; walks cycles 1..34.
    task automatic run_and_check(input int exp_correct, input real exp_cost, input bit poke_busy);
        for (int c = 1; c <= 34; c++) begin
            int   pos;
            int   s;
            logic on;
            tick();
            on  = (c <= 32);
            pos = (c - 1) % 16;
            s   = (pos % 8) / 2;
            check_bit($sformatf("busy@%0d", c), busy, on);
            check_bit($sformatf("training@%0d", c), training, on && (pos < 8));
            check_bit($sformatf("done@%0d", c), done, c == 33);
            check_real($sformatf("values0@%0d", c), values[0], on ? xor_a[s] : 0.0);
            check_real($sformatf("values1@%0d", c), values[1], on ? xor_b[s] : 0.0);
            check_real($sformatf("expected0@%0d", c), expected[0], on ? xor_y[s] : 0.0);
            check_int($sformatf("epoch@%0d", c), epoch, (c - 1) / 16);
            check_int($sformatf("correct@%0d", c), correct, (c <= 16) ? 0 : exp_correct);
`ifdef MLP_DRIVER_COST_EN
            if ((c == 17) || (c == 34)) check_real($sformatf("cost@%0d", c), cost, exp_cost);
`endif
            start   = 1'b0;
            load_en = 1'b0;
            if (poke_busy && (c == 5)) begin
                start            = 1'b1;
                load_en          = 1'b1;
                load_idx         = 2'd0;
                load_values[0]   = 9.0;
                load_values[1]   = 9.0;
                load_expected[0] = 1.0;
            end
        end
    endtask

    initial begin
        rst              = 1'b0;
        start            = 1'b0;
        load_en          = 1'b0;
        load_idx         = 2'd0;
        load_values[0]   = 0.0;
        load_values[1]   = 0.0;
        load_expected[0] = 0.0;
        pred_const       = 1'b0;

        tick();
        tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_training", training, 1'b0);
        check_int("rst_epoch", epoch, 0);
        check_int("rst_correct", correct, 0);
        check_real("rst_values0", values[0], 0.0);

        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            load_en          = 1'b1;
            load_idx         = 2'(i);
            load_values[0]   = xor_a[i];
            load_values[1]   = xor_b[i];
            load_expected[0] = xor_y[i];
            tick();
        end

        // Last entry is loaded in the same cycle as start and must be used by the run.
        load_en          = 1'b1;
        load_idx         = 2'd3;
        load_values[0]   = xor_a[3];
        load_values[1]   = xor_b[3];
        load_expected[0] = xor_y[3];
        start            = 1'b1;
        run_and_check(4, 0.0, 1'b1);

        pred_const = 1'b1;
        start      = 1'b1;
        run_and_check(2, 4.0 * $ln(2.0), 1'b0);

        pred_const = 1'b0;
        start      = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
        end
        check_bit("mid_busy", busy, 1'b1);
        check_real("mid_values0", values[0], xor_a[3]);
        rst = 1'b0;
        tick();
        check_bit("post_rst_busy", busy, 1'b0);
        check_bit("post_rst_training", training, 1'b0);
        check_bit("post_rst_done", done, 1'b0);
        check_int("post_rst_epoch", epoch, 0);
        check_int("post_rst_correct", correct, 0);
        check_real("post_rst_values1", values[1], 0.0);
        rst = 1'b1;
        tick();
        start = 1'b1;
        run_and_check(4, 0.0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mlp_epoch_driver.md
MLP_EPOCH_DRIVER -- requirements
Module: mlp_epoch_driver

Interface
REQ-001 SHALL have parameter inputs, default 2: the number of feature values per sample.
REQ-002 SHALL have parameter outputs, default 1: the number of expected/prediction values per sample.
REQ-003 SHALL have parameter num_samples, default 4: the number of entries in the sample table.
REQ-004 SHALL have parameter num_epochs, default 100: the number of epochs run per start.
REQ-005 SHALL have parameter threshold (real), default 0.5: the classification threshold.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-low reset (0 = reset).
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request to begin a run.
REQ-009 SHALL have ports load_en (input, 1 bit) and load_idx (input, $clog2(num_samples) bits): the sample-table write strobe and index.
REQ-010 SHALL have ports load_values (input, real[inputs-1:0]) and load_expected (input, real[outputs-1:0]): the sample-table write data.
REQ-011 SHALL have ports values (output, real[inputs-1:0]), expected (output, real[outputs-1:0]) and training (output, 1 bit): the drive into the MLP.
REQ-012 SHALL have port prediction, input, real[outputs-1:0]: the result returned from the MLP.
REQ-013 SHALL have ports busy (output, 1 bit) and done (output, 1 bit, one-cycle pulse).
REQ-014 SHALL have ports epoch (output, int) and correct (output, int): the current epoch index and the correct-count of the last completed evaluation.

Function
REQ-015 SHALL implement FSM states IDLE, TRAIN, EVAL and DONE.
REQ-016 SHALL go IDLE->TRAIN on start=1 in IDLE; start outside IDLE is ignored.
REQ-017 SHALL give each sample a 2-cycle slot: cycle A drives values/expected from table[i]; cycle B holds them.
REQ-018 SHALL sample prediction at the rising edge ending cycle B.
REQ-019 TRAIN SHALL present samples 0..num_samples-1 with training=1, then go to EVAL.
REQ-020 EVAL SHALL present the same sequence with training=0; a sample counts correct iff, for every output k, (prediction[k]<threshold)==(expected[k]<threshold).
REQ-021 One epoch SHALL last 4*num_samples cycles.
REQ-022 At the end of EVAL, correct SHALL update and epoch SHALL increment; if epoch reaches num_epochs, go to DONE, otherwise to TRAIN.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE; epoch and correct hold until the next start.
REQ-024 busy SHALL be 1 in TRAIN and EVAL only.
REQ-025 load_en SHALL write the table only in IDLE; a load and a start in the same cycle SHALL both take effect, and the run SHALL use the new entry.
REQ-026 A load_idx >= num_samples SHALL be ignored.
REQ-027 In IDLE, values/expected SHALL be 0.0 and training 0.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE from any state, including mid-epoch.
REQ-029 On reset, all outputs SHALL be 0 and the partial count SHALL be discarded.
REQ-030 The sample table SHALL NOT be cleared by reset.

Configuration
REQ-031 With macro MLP_DRIVER_COST_EN defined, the block SHALL add output cost (real): the summed binary cross-entropy over output 0 of the last EVAL, -(e*ln(p+epsilon)+(1-e)*ln(1-p+epsilon)), updated with correct.
REQ-032 Without MLP_DRIVER_COST_EN, port cost and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-033 The driver_state_t enum SHALL live in package Common, alongside the existing act_func and epsilon.
REQ-034 The sample table SHALL be the sub-module mlp_sample_store, with one write port and one combinational read port.

Verification
REQ-035 Load the XOR table, num_epochs=2, stub MLP with prediction=expected -> correct=4 after each epoch; done pulses at cycle 33 after start; epoch=2.
REQ-036 Stub with prediction constant 0.5 -> correct=2 (expected-1 samples match, expected-0 samples do not); with MLP_DRIVER_COST_EN, cost≈2.773 (4*ln2).
REQ-037 Assert rst=0 at cycle 7 of epoch 0 -> next cycle IDLE, busy=0, epoch=0, correct=0; a new start replays from sample 0 with the table intact.
REQ-038 Pulse start while busy -> no effect on the sequence or on timing; pulse load_en while busy -> table unchanged.
REQ-039 Check per-cycle drive: training=1 for cycles 1-8 and 0 for cycles 9-16 of each epoch, values change only on A cycles, load_idx=4 ignored.
